ft_cmd_sequencer: RTL
=====================

Name: ft_cmd_sequencer

Overview:
Command sequencer between the FT245 link FIFOs and the camera core. Pops host command bytes from the rx FIFO and decodes them into register writes, register reads and readout starts. Arbitrates the single tx FIFO write port between register-read responses and the CCD pixel byte stream. Runs in the FT clock domain on the FIFO sides that face the core.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed between a WRITE opcode byte and its data byte (used only with CMD_TIMEOUT_EN).
TIMEOUT_W, 20, width of the timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES.
RESP_TAG, 2'b10, bits [7:6] of every response header byte.

Ports:
clk  in  1  single block clock.
rst_n  in  1  asynchronous active-low reset.
rx_rdata  in  8  rx FIFO head byte, first-word-fall-through; valid when rx_rempty=0.
rx_rempty  in  1  rx FIFO empty.
rx_rinc  out  1  pop rx FIFO head this cycle.
tx_wdata  out  8  byte to tx FIFO.
tx_winc  out  1  push tx_wdata this cycle.
tx_wfull  in  1  tx FIFO full.
reg_addr  out  6  register address, held from decode until the next command.
reg_wdata  out  8  register write data.
reg_we  out  1  1-cycle write strobe.
reg_re  out  1  1-cycle read strobe.
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re.
readout_start  out  1  1-cycle pulse that starts a CCD frame readout.
pix_data  in  8  pixel stream byte.
pix_valid  in  1  pixel byte valid.
pix_last  in  1  last byte of the frame, qualified by pix_valid.
pix_ready  out  1  pixel byte accepted when pix_valid & pix_ready.
cmd_busy  out  1  high whenever state != S_IDLE.
err_count  out  8  saturating count of timeout errors.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. Reset forces state S_IDLE. All strobes (rx_rinc, tx_winc, reg_we, reg_re, readout_start, pix_ready) reset to 0. reg_addr, reg_wdata, tx_wdata and err_count reset to 0. Reset mid-stream or mid-response abandons the operation; no partial byte is pushed.
- State is registered. Strobes are decoded combinationally from state and inputs.
- Command byte: op=[7:6], addr=[5:0]. Opcodes: 00 NOP, 01 WRITE, 10 READ, 11 START.
- S_IDLE, when rx_rempty=0:
  - rx_rinc=1 and addr is latched to reg_addr.
  - NOP stays in S_IDLE.
  - WRITE goes to S_WDATA.
  - READ goes to S_RD.
  - START pulses readout_start in the same cycle and goes to S_STREAM.
- S_WDATA, when rx_rempty=0: rx_rinc=1, reg_we=1, reg_wdata=rx_rdata, then S_IDLE. Opcode pop to reg_we latency is 1 cycle minimum; the state waits indefinitely on an empty FIFO.
- S_RD: reg_re=1 for exactly 1 cycle, then S_RDCAP.
- S_RDCAP: capture reg_rdata into the response register, then S_HDR.
- S_HDR: tx_wdata = {RESP_TAG, reg_addr}; tx_winc=1 only when tx_wfull=0; on push go to S_DATA.
- S_DATA: push the captured byte when tx_wfull=0, then S_IDLE. Pop to header push takes 3 cycles minimum.
- S_STREAM: pix_ready = ~tx_wfull; tx_winc = pix_valid & ~tx_wfull; tx_wdata = pix_data.
  - On an accepted byte with pix_last=1, go to S_IDLE.
  - rx FIFO is not popped while streaming; commands queue in the rx FIFO.
  - Responses are never interleaved with pixel bytes.
- pix_ready=0 in every state other than S_STREAM.
- tx_winc never asserts while tx_wfull=1. rx_rinc never asserts while rx_rempty=1.
- A zero-length frame (pix_valid=0 forever) holds S_STREAM; only reset recovers.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter clears on entry to S_WDATA and increments each cycle while in S_WDATA.
  - When it reaches TIMEOUT_CYCLES: abandon the write, increment err_count (saturating at 255), return to S_IDLE. No reg_we is issued.
  - A data byte arriving in the same cycle as the timeout wins: the write completes and no error is counted.
- Undefined: no counter is present, S_WDATA waits forever, and err_count is tied to 0.

Decomposition:
- Package ft_cmd_pkg:
  - opcode constants OP_NOP, OP_WRITE, OP_READ, OP_START;
  - state enum S_IDLE, S_WDATA, S_RD, S_RDCAP, S_HDR, S_DATA, S_STREAM;
  - default RESP_TAG;
  - field-slice constants for op and addr.
- One sub-module, ft_cmd_timer (load/enable/expire counter), instantiated only under CMD_TIMEOUT_EN.

Test Plan:
- Write: rx bytes 0x45, 0x3C -> reg_we one cycle with reg_addr=0x05, reg_wdata=0x3C; no tx_winc.
- Read: rx byte 0x85, reg_rdata=0xA7 after reg_re -> tx bytes 0x85, 0xA7 in order; reg_re high exactly 1 cycle.
- Read backpressure: tx_wfull=1 for 10 cycles during S_HDR -> no tx_winc; after release, bytes 0x85, 0xA7 are pushed once each.
- Stream: rx 0xC0 -> readout_start 1 cycle; 16 pixel bytes 0x00..0x0F with pix_last on 0x0F, random tx_wfull -> tx gets exactly 0x00..0x0F; a queued 0x81 command stays unpopped until after 0x0F.
- NOP and back-to-back: rx 0x00, 0x41, 0x12, 0x42, 0x34 -> two writes (addr 1 = 0x12, addr 2 = 0x34); rx_rinc total 5.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8: rx 0x41 then empty for 20 cycles -> state back to S_IDLE, err_count=1, no reg_we. Reset asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ft_cmd_pkg.sv
// Shared opcodes, command-byte field positions and sequencer states for ft_cmd_sequencer.
package ft_cmd_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_START = 2'b11;

    localparam logic [1:0] RESP_TAG_DEFAULT = 2'b10;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 6;
    localparam int ADDR_HI = 5;
    localparam int ADDR_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_RD,
        S_RDCAP,
        S_HDR,
        S_DATA,
        S_STREAM
    } state_t;

endpackage

// File: rtl/ft_cmd_timer.sv
// WRITE-data timeout counter: cleared by i_load, counts while i_en, flags the final cycle.
// Only built when CMD_TIMEOUT_EN is defined; otherwise the sequencer has no timer at all.
`ifdef CMD_TIMEOUT_EN
module ft_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [TIMEOUT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/ft_cmd_sequencer.sv
// FT245 command sequencer: decodes rx command bytes into register accesses and readout starts,
// and arbitrates the tx FIFO between read responses and the pixel stream. Option: CMD_TIMEOUT_EN.
module ft_cmd_sequencer
    import ft_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TIMEOUT_W      = 20,
    parameter logic [1:0] RESP_TAG       = RESP_TAG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_rdata,
    input  logic       rx_rempty,
    output logic       rx_rinc,
    output logic [7:0] tx_wdata,
    output logic       tx_winc,
    input  logic       tx_wfull,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       readout_start,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       cmd_busy,
    output logic [7:0] err_count
);

    if (2**TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("TIMEOUT_W is too narrow to hold TIMEOUT_CYCLES");
    end

    state_t     r_state, w_next;
    logic [5:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_resp;
    logic [1:0] w_op;
    logic       w_expire;

    assign w_op     = rx_rdata[OP_HI:OP_LO];
    assign reg_addr = r_addr;
    assign cmd_busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        rx_rinc       = 1'b0;
        tx_winc       = 1'b0;
        tx_wdata      = 8'd0;
        reg_we        = 1'b0;
        reg_re        = 1'b0;
        reg_wdata     = r_wdata;
        readout_start = 1'b0;
        pix_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so a non-empty FIFO cannot pop or start a frame during reset.
                if (!rx_rempty && rst_n) begin
                    rx_rinc = 1'b1;
                    case (w_op)
                        OP_NOP:   w_next = S_IDLE;
                        OP_WRITE: w_next = S_WDATA;
                        OP_READ:  w_next = S_RD;
                        OP_START: begin
                            readout_start = 1'b1;
                            w_next        = S_STREAM;
                        end
                    endcase
                end
            end
            S_WDATA: begin
                // A data byte present in the expiry cycle still completes the write.
                if (!rx_rempty) begin
                    rx_rinc   = 1'b1;
                    reg_we    = 1'b1;
                    reg_wdata = rx_rdata;
                    w_next    = S_IDLE;
                end else if (w_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_RD: begin
                reg_re = 1'b1;
                w_next = S_RDCAP;
            end
            S_RDCAP: w_next = S_HDR;
            S_HDR: begin
                tx_wdata = {RESP_TAG, r_addr};
                if (!tx_wfull) begin
                    tx_winc = 1'b1;
                    w_next  = S_DATA;
                end
            end
            S_DATA: begin
                tx_wdata = r_resp;
                if (!tx_wfull) begin
                    tx_winc = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_STREAM: begin
                pix_ready = ~tx_wfull;
                tx_wdata  = pix_data;
                tx_winc   = pix_valid & ~tx_wfull;
                if (pix_valid && !tx_wfull && pix_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 6'd0;
            r_wdata <= 8'd0;
            r_resp  <= 8'd0;
        end else begin
            if (r_state == S_IDLE && rx_rinc) begin
                r_addr <= rx_rdata[ADDR_HI:ADDR_LO];
            end
            if (reg_we) begin
                r_wdata <= rx_rdata;
            end
            if (r_state == S_RDCAP) begin
                r_resp <= reg_rdata;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic       w_load;
    logic       w_tmr_en;
    logic [7:0] r_err;

    assign w_load   = (r_state == S_IDLE) && rx_rinc && (w_op == OP_WRITE);
    assign w_tmr_en = (r_state == S_WDATA);

    ft_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_en    (w_tmr_en),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 8'd0;
        end else if (w_tmr_en && rx_rempty && w_expire && r_err != 8'hFF) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_count = r_err;
`else
    assign w_expire  = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule
